// File: rtl/proc_mem_arbiter_pkg.sv
// proc_mem_arbiter_pkg: memory message layouts, port ids and the in-flight tag format.
package proc_mem_arbiter_pkg;

    localparam logic PORT_IMEM = 1'b0;
    localparam logic PORT_DMEM = 1'b1;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    typedef struct packed {
        logic       src;
        logic [7:0] opaque;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    // Opaque sent to memory: source port in the top bit, sequence number below.
    function automatic logic [7:0] mk_opaque(logic src, logic [6:0] seq);
        return {src, seq};
    endfunction

endpackage

// File: rtl/proc_mem_arbiter_tag_fifo.sv
// proc_mem_arbiter_tag_fifo: normal-mode (registered, no bypass) circular FIFO of in-flight tags.
module proc_mem_arbiter_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq_val,
    input  logic [WIDTH-1:0] enq_msg,
    input  logic             deq_rdy,
    output logic             deq_val,
    output logic [WIDTH-1:0] deq_msg,
    output logic [CW-1:0]    num_free_entries
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             do_enq, do_deq;

    assign do_enq           = enq_val && (count != CW'(DEPTH));
    assign do_deq           = deq_rdy && (count != '0);
    assign deq_val          = count != '0;
    assign deq_msg          = mem[rd_ptr];
    assign num_free_entries = CW'(DEPTH) - count;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + 1'b1;
            if (do_deq) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_enq) - CW'(do_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr] <= enq_msg;
    end

endmodule

// File: rtl/proc_mem_arbiter.sv
// proc_mem_arbiter: round-robin imem/dmem arbiter onto one memory port with in-order response steering.
module proc_mem_arbiter
    import proc_mem_arbiter_pkg::*;
#(
    parameter int p_max_inflight = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [76:0] req0_msg,
    input  logic        req0_val,
    output logic        req0_rdy,
    input  logic [76:0] req1_msg,
    input  logic        req1_val,
    output logic        req1_rdy,
    output logic [46:0] resp0_msg,
    output logic        resp0_val,
    input  logic        resp0_rdy,
    output logic [46:0] resp1_msg,
    output logic        resp1_val,
    input  logic        resp1_rdy,
    output logic [76:0] memreq_msg,
    output logic        memreq_val,
    input  logic        memreq_rdy,
    input  logic [46:0] memresp_msg,
    input  logic        memresp_val,
    output logic        memresp_rdy,
    output logic        tag_err
);

    localparam int CW = $clog2(p_max_inflight + 1);

    mem_req_4B_t  req_sel, req_out;
    mem_resp_4B_t mresp, resp_out;
    tag_t         tag_in, head;
    logic         grant, prio, full, head_val, fire, pop;
    logic [6:0]   seq;
    logic [CW-1:0] num_free;

    // full comes from registered occupancy so a same-cycle pop never opens a grant.
    assign full       = num_free == '0;
    assign grant      = (req0_val && req1_val) ? prio : req1_val;
    assign memreq_val = !reset && !full && (req0_val || req1_val);
    assign req0_rdy   = !reset && (grant == PORT_IMEM) && memreq_rdy && !full;
    assign req1_rdy   = !reset && (grant == PORT_DMEM) && memreq_rdy && !full;
    assign fire       = memreq_val && memreq_rdy;

    always_comb begin
        req_sel        = grant ? req1_msg : req0_msg;
        req_out        = req_sel;
        req_out.opaque = mk_opaque(grant, seq);
        tag_in         = '{src: grant, opaque: req_sel.opaque};
    end

    assign memreq_msg = req_out;

    always_comb begin
        mresp           = memresp_msg;
        resp_out        = mresp;
        resp_out.opaque = head.opaque;
    end

    assign resp0_msg   = resp_out;
    assign resp1_msg   = resp_out;
    assign resp0_val   = !reset && memresp_val && head_val && (head.src == PORT_IMEM);
    assign resp1_val   = !reset && memresp_val && head_val && (head.src == PORT_DMEM);
    assign memresp_rdy = !reset && head_val && (head.src ? resp1_rdy : resp0_rdy);
    assign pop         = memresp_val && memresp_rdy;

    proc_mem_arbiter_tag_fifo #(
        .DEPTH (p_max_inflight),
        .WIDTH (TAG_W)
    ) tag_fifo (
        .clk              (clk),
        .reset            (reset),
        .enq_val          (fire),
        .enq_msg          (tag_in),
        .deq_rdy          (pop),
        .deq_val          (head_val),
        .deq_msg          (head),
        .num_free_entries (num_free)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            prio    <= PORT_DMEM;
            seq     <= '0;
            tag_err <= 1'b0;
        end else begin
            if (fire) begin
                prio <= !grant;
                seq  <= seq + 7'd1;
            end
            if (pop && (mresp.opaque[7] != head.src)) tag_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// tb_proc_mem_arbiter: directed scenarios plus randomized traffic checked by a queue-based scoreboard.
module tb_proc_mem_arbiter;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [76:0] req0_msg = '0, req1_msg = '0, memreq_msg;
    logic        req0_val = 1'b0, req1_val = 1'b0, req0_rdy, req1_rdy;
    logic [46:0] resp0_msg, resp1_msg, memresp_msg = '0;
    logic        resp0_val, resp1_val, resp0_rdy = 1'b1, resp1_rdy = 1'b1;
    logic        memreq_val, memreq_rdy = 1'b1, memresp_val = 1'b0, memresp_rdy, tag_err;

    always #5 clk = ~clk;

    proc_mem_arbiter #(.p_max_inflight(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_msg    (req0_msg),
        .req0_val    (req0_val),
        .req0_rdy    (req0_rdy),
        .req1_msg    (req1_msg),
        .req1_val    (req1_val),
        .req1_rdy    (req1_rdy),
        .resp0_msg   (resp0_msg),
        .resp0_val   (resp0_val),
        .resp0_rdy   (resp0_rdy),
        .resp1_msg   (resp1_msg),
        .resp1_val   (resp1_val),
        .resp1_rdy   (resp1_rdy),
        .memreq_msg  (memreq_msg),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memresp_msg (memresp_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .tag_err     (tag_err)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [76:0] act, input logic [76:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred with nothing expected", name);
    endtask

    function automatic logic [76:0] mk_req(logic [2:0] t, logic [7:0] o, logic [31:0] a, logic [31:0] d);
        return {t, o, a, 2'b00, d};
    endfunction

    function automatic logic [46:0] mk_resp(logic [2:0] t, logic [7:0] o, logic [31:0] d);
        return {t, o, 2'b00, 2'b00, d};
    endfunction

    function automatic logic [31:0] mem_data(logic [31:0] a);
        return a ^ 32'hc3a5_0f1e;
    endfunction

    // Reference model: requests outstanding at memory, in issue order.
    typedef struct {
        logic [2:0]  t;
        logic [7:0]  o;
        logic [31:0] a;
        logic        src;
    } flight_t;

    flight_t     inflight[$];
    logic [76:0] exp_req[$], mem_q[$];
    logic [46:0] exp_r0[$], exp_r1[$];
    logic [6:0]  seq_m;
    logic        last_win;
    bit          track = 0, pred_fire = 0, pred_pop = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        req0_val = 1'b0;
        req1_val = 1'b0;
        memresp_val = 1'b0;
        memreq_rdy = 1'b1;
        resp0_rdy = 1'b1;
        resp1_rdy = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic rand_cycle(input bit drain);
        logic [76:0] m0, m1, m;
        logic        win;
        flight_t     f;
        tick();
        m0 = mk_req(3'($urandom_range(0, 1)), 8'($urandom), $urandom, $urandom);
        m1 = mk_req(3'($urandom_range(0, 1)), 8'($urandom), $urandom, $urandom);
        req0_msg = m0;
        req1_msg = m1;
        req0_val = !drain && ($urandom_range(0, 2) != 0);
        req1_val = !drain && ($urandom_range(0, 2) != 0);
        memreq_rdy = drain || ($urandom_range(0, 3) != 0);
        resp0_rdy = drain || ($urandom_range(0, 3) != 0);
        resp1_rdy = drain || ($urandom_range(0, 3) != 0);
        memresp_val = (mem_q.size() != 0) && (drain || ($urandom_range(0, 2) != 0));
        memresp_msg = '0;
        if (mem_q.size() != 0)
            memresp_msg = mk_resp(mem_q[0][76:74], mem_q[0][73:66], mem_data(mem_q[0][65:34]));
        pred_pop = memresp_val && (inflight.size() != 0) && (inflight[0].src ? resp1_rdy : resp0_rdy);
        pred_fire = (req0_val || req1_val) && memreq_rdy && (inflight.size() < D);
        win = (req0_val && req1_val) ? !last_win : req1_val;
        if (pred_pop) begin
            f = inflight.pop_front();
            if (f.src) exp_r1.push_back(mk_resp(f.t, f.o, mem_data(f.a)));
            else exp_r0.push_back(mk_resp(f.t, f.o, mem_data(f.a)));
        end
        if (pred_fire) begin
            m = win ? m1 : m0;
            exp_req.push_back({m[76:74], win, seq_m, m[65:0]});
            inflight.push_back('{t: m[76:74], o: m[73:66], a: m[65:34], src: win});
            seq_m++;
            last_win = win;
        end
    endtask

    always @(negedge clk) begin
        if (track) begin
            chk("memreq_fire", memreq_val && memreq_rdy, pred_fire);
            chk("memresp_fire", memresp_val && memresp_rdy, pred_pop);
            chk("resp_onehot", resp0_val && resp1_val, 1'b0);
            if (memreq_val && memreq_rdy) begin
                mem_q.push_back(memreq_msg);
                if (exp_req.size() == 0) fail("memreq_unexpected");
                else chk("memreq_msg", memreq_msg, exp_req.pop_front());
            end
            if (memresp_val && memresp_rdy && mem_q.size() != 0) mem_q.delete(0);
            if (resp0_val && resp0_rdy) begin
                if (exp_r0.size() == 0) fail("resp0_unexpected");
                else chk("resp0_msg", resp0_msg, exp_r0.pop_front());
            end
            if (resp1_val && resp1_rdy) begin
                if (exp_r1.size() == 0) fail("resp1_unexpected");
                else chk("resp1_msg", resp1_msg, exp_r1.pop_front());
            end
        end
    end

    initial begin
        do_reset();
        smp();
        chk("rst_tag_err", tag_err, 1'b0);
        chk("rst_memresp_rdy", memresp_rdy, 1'b0);
        chk("rst_memreq_val", memreq_val, 1'b0);

        // single imem read
        tick();
        req0_val = 1'b1;
        req0_msg = mk_req(3'd0, 8'h5a, 32'h200, 32'h0);
        smp();
        chk("t1_memreq_val", memreq_val, 1'b1);
        chk("t1_memreq_msg", memreq_msg, mk_req(3'd0, 8'h00, 32'h200, 32'h0));
        chk("t1_req0_rdy", req0_rdy, 1'b1);
        chk("t1_req1_rdy", req1_rdy, 1'b0);
        tick();
        req0_val = 1'b0;
        memresp_val = 1'b1;
        memresp_msg = mk_resp(3'd0, 8'h00, 32'hdeadbeef);
        smp();
        chk("t1_resp0_val", resp0_val, 1'b1);
        chk("t1_resp0_msg", resp0_msg, mk_resp(3'd0, 8'h5a, 32'hdeadbeef));
        chk("t1_resp1_val", resp1_val, 1'b0);
        chk("t1_memresp_rdy", memresp_rdy, 1'b1);
        tick();
        memresp_val = 1'b0;

        // both ports always valid: alternation, fill, pop without same-cycle grant
        do_reset();
        req0_val = 1'b1;
        req0_msg = mk_req(3'd0, 8'h11, 32'h100, 32'h0);
        req1_val = 1'b1;
        req1_msg = mk_req(3'd0, 8'h22, 32'h300, 32'h0);
        for (int i = 0; i < 4; i++) begin
            logic s;
            s = (i % 2 == 0);
            smp();
            chk("rr_req1_rdy", req1_rdy, s);
            chk("rr_memreq_msg", memreq_msg, mk_req(3'd0, {s, 7'(i)}, s ? 32'h300 : 32'h100, 32'h0));
            tick();
        end
        smp();
        chk("full_memreq_val", memreq_val, 1'b0);
        chk("full_req0_rdy", req0_rdy, 1'b0);
        chk("full_req1_rdy", req1_rdy, 1'b0);
        tick();
        memresp_val = 1'b1;
        memresp_msg = mk_resp(3'd0, 8'h80, 32'h1);
        smp();
        chk("full_pop_rdy", memresp_rdy, 1'b1);
        chk("full_pop_resp1_msg", resp1_msg, mk_resp(3'd0, 8'h22, 32'h1));
        chk("full_pop_no_grant", memreq_val, 1'b0);
        tick();
        memresp_val = 1'b0;
        smp();
        chk("after_pop_grant", memreq_val, 1'b1);
        chk("after_pop_msg", memreq_msg, mk_req(3'd0, 8'h84, 32'h300, 32'h0));
        tick();
        req0_val = 1'b0;
        req1_val = 1'b0;

        // head blocked by resp0_rdy
        do_reset();
        req0_val = 1'b1;
        req0_msg = mk_req(3'd0, 8'h44, 32'h400, 32'h0);
        smp();
        chk("il_req0_msg", memreq_msg, mk_req(3'd0, 8'h00, 32'h400, 32'h0));
        tick();
        req0_val = 1'b0;
        req1_val = 1'b1;
        req1_msg = mk_req(3'd1, 8'h55, 32'h500, 32'h1234);
        smp();
        chk("il_req1_msg", memreq_msg, mk_req(3'd1, 8'h81, 32'h500, 32'h1234));
        tick();
        req1_val = 1'b0;
        resp0_rdy = 1'b0;
        memresp_val = 1'b1;
        memresp_msg = mk_resp(3'd0, 8'h00, 32'haaaa);
        smp();
        chk("il_blocked_rdy", memresp_rdy, 1'b0);
        chk("il_blocked_resp1", resp1_val, 1'b0);
        chk("il_blocked_resp0", resp0_val, 1'b1);
        tick();
        resp0_rdy = 1'b1;
        smp();
        chk("il_open_rdy", memresp_rdy, 1'b1);
        chk("il_resp0_msg", resp0_msg, mk_resp(3'd0, 8'h44, 32'haaaa));
        tick();
        memresp_msg = mk_resp(3'd1, 8'h81, 32'hbbbb);
        smp();
        chk("il_resp1_val", resp1_val, 1'b1);
        chk("il_resp0_idle", resp0_val, 1'b0);
        chk("il_resp1_msg", resp1_msg, mk_resp(3'd1, 8'h55, 32'hbbbb));
        tick();
        memresp_val = 1'b0;

        // tag mismatch
        do_reset();
        req1_val = 1'b1;
        req1_msg = mk_req(3'd0, 8'h33, 32'h600, 32'h0);
        smp();
        chk("te_memreq_msg", memreq_msg, mk_req(3'd0, 8'h80, 32'h600, 32'h0));
        tick();
        req1_val = 1'b0;
        memresp_val = 1'b1;
        memresp_msg = mk_resp(3'd0, 8'h01, 32'hcafe);
        smp();
        chk("te_resp1_val", resp1_val, 1'b1);
        chk("te_resp0_val", resp0_val, 1'b0);
        chk("te_resp1_msg", resp1_msg, mk_resp(3'd0, 8'h33, 32'hcafe));
        chk("te_not_yet", tag_err, 1'b0);
        tick();
        memresp_val = 1'b0;
        smp();
        chk("te_set", tag_err, 1'b1);

        // reset with three outstanding
        tick();
        req0_val = 1'b1;
        req0_msg = mk_req(3'd0, 8'h66, 32'h700, 32'h0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        memresp_val = 1'b1;
        memresp_msg = mk_resp(3'd0, 8'h01, 32'h0);
        smp();
        chk("mr_tag_err_held", tag_err, 1'b1);
        chk("mr_memreq_val", memreq_val, 1'b0);
        chk("mr_req0_rdy", req0_rdy, 1'b0);
        chk("mr_memresp_rdy", memresp_rdy, 1'b0);
        chk("mr_resp0_val", resp0_val, 1'b0);
        tick();
        reset = 1'b0;
        req0_val = 1'b0;
        smp();
        chk("mr_tag_err_clr", tag_err, 1'b0);
        chk("mr_empty_rdy", memresp_rdy, 1'b0);
        chk("mr_empty_resp0", resp0_val, 1'b0);
        tick();
        memresp_val = 1'b0;
        req0_val = 1'b1;
        req1_val = 1'b1;
        smp();
        chk("mr_prio_seq", memreq_msg, mk_req(3'd0, 8'h80, 32'h600, 32'h0));
        chk("mr_req1_rdy", req1_rdy, 1'b1);
        tick();
        req0_val = 1'b0;
        req1_val = 1'b0;
        memresp_val = 1'b1;
        memresp_msg = mk_resp(3'd0, 8'h80, 32'h9);
        smp();
        chk("mr_new_rdy", memresp_rdy, 1'b1);
        chk("mr_new_resp1", resp1_val, 1'b1);
        tick();
        memresp_val = 1'b0;

        // randomized traffic against the scoreboard
        do_reset();
        inflight.delete();
        exp_req.delete();
        mem_q.delete();
        exp_r0.delete();
        exp_r1.delete();
        seq_m = '0;
        last_win = 1'b0;
        pred_fire = 0;
        pred_pop = 0;
        track = 1;
        for (int i = 0; i < 1500; i++) rand_cycle(1'b0);
        for (int i = 0; i < 200 && (inflight.size() != 0 || mem_q.size() != 0); i++) rand_cycle(1'b1);
        smp();
        track = 0;
        chk("drain_inflight", 32'(inflight.size()), 32'd0);
        chk("drain_exp_req", 32'(exp_req.size()), 32'd0);
        chk("drain_exp_r0", 32'(exp_r0.size()), 32'd0);
        chk("drain_exp_r1", 32'(exp_r1.size()), 32'd0);
        chk("rand_tag_err", tag_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/proc_mem_arbiter.md
# proc_mem_arbiter

Two-to-one memory port arbiter between a pipelined processor's instruction and data memory interfaces and a single shared memory port. It sits directly downstream of the processor's imem/dmem request bypass queues and directly upstream of its imem drop unit and dmem response input. Round-robin arbitration selects requests, and in-order responses are steered back to the requesting port. A tag FIFO records the source and original opaque of every in-flight request.

## Interface
- p_max_inflight, 4: maximum outstanding requests; tag FIFO depth; power of two, ≥2.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req0_msg  in  77  mem_req_4B_t from imem (port 0).
- req0_val  in  1; req0_rdy  out  1.
- req1_msg  in  77  mem_req_4B_t from dmem (port 1).
- req1_val  in  1; req1_rdy  out  1.
- resp0_msg  out  47  mem_resp_4B_t to imem.
- resp0_val  out  1; resp0_rdy  in  1.
- resp1_msg  out  47  mem_resp_4B_t to dmem.
- resp1_val  out  1; resp1_rdy  in  1.
- memreq_msg  out  77; memreq_val  out  1; memreq_rdy  in  1.
- memresp_msg  in  47; memresp_val  in  1; memresp_rdy  out  1.
- tag_err  out  1  sticky: response opaque source bit disagreed with the FIFO head.

## Operation
- Memory returns responses strictly in request order. The arbiter relies on this.
- Grant is combinational. It is given only if the FIFO is not full. If exactly one reqN_val is high, that port wins. If both are high, the port named by prio wins.
- prio: 1-bit register, reset to 1 (dmem first). On a memreq fire (val&&rdy), prio becomes the non-granted port. With no fire, prio holds. A stalled grant therefore stays stable while inputs hold.
- memreq_msg is the winner's message with opaque replaced by {src[0], seq[6:0]}.
  - seq: 7-bit counter, reset 0, increments on each fire, wraps 127→0.
- reqN_rdy = (grant==N) && memreq_rdy && !full. The loser sees rdy=0.
- On fire, push {src, original opaque[7:0]} into the tag FIFO.
- Response steering: head.src selects the port. respN_val = memresp_val && !empty && head.src==N. respN_msg = memresp_msg with opaque restored to head.opaque. Non-selected resp_val=0.
- memresp_rdy = !empty && resp[head.src]_rdy. A response arriving with the FIFO empty is never accepted (rdy=0).
- Pop the FIFO when memresp fires.
- On a response fire where memresp_msg.opaque[7] != head.src: tag_err is set to 1 and held until reset. The response is still routed by head.src.
- full is the registered occupancy, not a bypass. When full, a pop in the same cycle does not enable a grant (no combinational resp→req path).
- A push and a pop in the same cycle leave the count unchanged.

## Timing
- Request path: zero latency, combinational valid/message pass-through.
- Response path: zero latency, combinational.
- No combinational path from memresp_* or respN_rdy to memreq_val or reqN_rdy.
- Reset values: prio=1, seq=0, FIFO empty, tag_err=0. All val outputs and rdy outputs are 0 during reset.
- Reset mid-operation discards in-flight tags. The environment must also reset memory.
- Throughput: one request per cycle and one response per cycle, concurrently.

## Structure
- Shared package / header vc/mem-msgs.v: mem_req_4B_t, mem_resp_4B_t.
- Local constants: PORT_IMEM=0, PORT_DMEM=1, tag struct {src:1, opaque:8} = 9 bits.
- Sub-module: vc_Queue in normal (non-bypass, non-pipe) mode, width 9, depth p_max_inflight, used as the tag FIFO. Its num_free_entries==0 provides full.
- Arbitration, prio and seq registers, and tag_err live in the top-level module.

## Test plan
- Single imem read to addr 0x200, memory returns data 0xdeadbeef.
  - memreq opaque 0x00; resp0 gets 0xdeadbeef with opaque 0x00; resp1_val stays 0.
- Both ports valid every cycle after reset, memreq_rdy=1.
  - Grants alternate dmem, imem, dmem, imem.
  - memreq opaques are 0x80, 0x01, 0x82, 0x03.
- Five back-to-back dmem requests with memresp held off (p_max_inflight=4).
  - Four fires, then req1_rdy=0.
  - The first response pops the FIFO. A grant resumes the following cycle, not the same cycle.
- Interleaved imem/dmem requests; resp0_rdy=0 while the head is imem.
  - memresp_rdy=0 and resp1_val=0 until resp0_rdy rises. Order is preserved.
- Memory returns opaque 0x01 while the head src is dmem.
  - tag_err rises the next cycle and stays 1 until reset. The response goes to port 1.
- Assert reset with 3 requests outstanding.
  - FIFO empty, prio=1, seq=0, tag_err=0.
  - memresp_rdy=0 until a new request fires.
